// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and bit-period helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Clocks per bit; integer division, so the baud rate is rounded up slightly.
  function automatic int unsigned pulse_width(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Single-wire UART link; the transmitter drives sig, the receiver samples it.
interface uart_if;
  logic sig;

  modport tx (output sig);
  modport rx (input sig);
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers producer words and serialises them LSB first with
// a start bit and STOP_BITS stop bits; consecutive frames run without a gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  uart_if.tx                          txif,
  input  logic [DATA_WIDTH-1:0]       sensor_data,
  input  logic                        sensor_valid,
  output logic                        sensor_ready,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned PULSE_WIDTH = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W       = $clog2(STOP_BITS * PULSE_WIDTH) + 1;
  localparam int unsigned IDX_W       = $clog2(DATA_WIDTH) + 1;

  tx_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop_c;
  logic                  line_c;

  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (sensor_valid),
    .wr_data (sensor_data),
    .pop     (pop_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign sensor_ready = !fifo_full;
  assign tx_busy      = (state != IDLE) || !fifo_empty;
  assign pop_c        = !fifo_empty && ((state == IDLE) || ((state == STOP) && (cnt == '0)));

  // Line level owed to the current state; registered one cycle later onto the wire.
  always_comb begin
    line_c = 1'b1;
    case (state)
      START:   line_c = 1'b0;
      DATA:    line_c = shift_reg[0];
      default: line_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      txif.sig  <= 1'b1;
    end else begin
      txif.sig <= line_c;
      case (state)
        IDLE: begin
          if (pop_c) begin
            shift_reg <= fifo_rd_data;
            cnt       <= CNT_W'(PULSE_WIDTH - 1);
            state     <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            cnt     <= CNT_W'(PULSE_WIDTH - 1);
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift_reg <= shift_reg >> 1;
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              cnt   <= CNT_W'(STOP_BITS * PULSE_WIDTH - 1);
              state <= STOP;
            end else begin
              cnt     <= CNT_W'(PULSE_WIDTH - 1);
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        STOP: begin
          // Chain straight into the next start bit when a word is waiting.
          if (cnt == '0) begin
            if (pop_c) begin
              shift_reg <= fifo_rd_data;
              cnt       <= CNT_W'(PULSE_WIDTH - 1);
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line waveforms compared against a frame-level
// timing model, plus an independent loopback decoder of the recorded line.
module tb_uart_tx;

  localparam int PW   = 10;
  localparam int LOGN = 16384;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] d1   = '0;
  logic [7:0] d2   = '0;
  logic       v1   = 1'b0;
  logic       v2   = 1'b0;
  logic       r1, r2, b1, b2;
  logic [2:0] lvl1, lvl2;

  uart_if tx1();
  uart_if tx2();

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(10_000_000), .CLK_FREQ(100_000_000),
            .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rstn(rstn), .txif(tx1), .sensor_data(d1), .sensor_valid(v1),
    .sensor_ready(r1), .tx_busy(b1), .fifo_level(lvl1));

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(10_000_000), .CLK_FREQ(100_000_000),
            .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rstn(rstn), .txif(tx2), .sensor_data(d2), .sensor_valid(v2),
    .sensor_ready(r2), .tx_busy(b2), .fifo_level(lvl2));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic log1 [LOGN];
  logic log2 [LOGN];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  // log[k] holds the line value right after rising edge k
  always @(negedge clk) if (cyc < LOGN) begin
    log1[cyc] = tx1.sig;
    log2[cyc] = tx2.sig;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- reference model: frame schedule ----------------
  int         m_start[$];
  logic [7:0] m_byte[$];
  int         m_end;
  int         m_sb;
  logic [7:0] rx_q[$];
  int         wd_first;
  logic       wd_got;

  function automatic void model_clear(input int sb);
    m_start.delete();
    m_byte.delete();
    m_end = 0;
    m_sb  = sb;
  endfunction

  function automatic int frame_len();
    return (1 + 8 + m_sb) * PW;
  endfunction

  // A word accepted on edge pe starts 2 edges later, or right after the previous frame.
  function automatic void model_add(input int pe, input logic [7:0] b);
    int s;
    s = (pe + 2 > m_end) ? pe + 2 : m_end;
    m_start.push_back(s);
    m_byte.push_back(b);
    m_end = s + frame_len();
  endfunction

  function automatic logic model_line(input int k);
    logic v;
    logic [7:0] bb;
    int slot;
    v = 1'b1;
    foreach (m_start[i]) begin
      if (k >= m_start[i] && k < m_start[i] + frame_len()) begin
        slot = (k - m_start[i]) / PW;
        bb   = m_byte[i];
        if (slot == 0)      v = 1'b0;
        else if (slot <= 8) v = bb[slot-1];
        else                v = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic line_at(input bit sel, input int k);
    return sel ? log2[k] : log1[k];
  endfunction

  function automatic int wave_diffs(input bit sel, input int a, input int b);
    int n;
    n = 0;
    wd_first = -1;
    wd_got = 1'bx;
    for (int k = a; k < b; k++) begin
      if (line_at(sel, k) !== model_line(k)) begin
        n++;
        if (wd_first < 0) begin
          wd_first = k;
          wd_got   = line_at(sel, k);
        end
      end
    end
    return n;
  endfunction

  // Loopback receiver: falling edge marks a start bit, data sampled mid-bit.
  function automatic void rx_decode(input bit sel, input int a, input int b);
    int k;
    logic [7:0] by;
    rx_q.delete();
    k = a;
    while (k < b) begin
      if (line_at(sel, k - 1) === 1'b1 && line_at(sel, k) === 1'b0) begin
        for (int i = 0; i < 8; i++) by[i] = line_at(sel, k + PW * (i + 1) + PW / 2);
        rx_q.push_back(by);
        k = k + PW * 9 + PW / 2;
      end else begin
        k++;
      end
    end
  endfunction

  function automatic int rx_diffs();
    int n;
    n = 0;
    if (rx_q.size() != m_byte.size()) return -1;
    foreach (rx_q[i]) if (rx_q[i] !== m_byte[i]) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_until(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge e.
  task automatic push(input bit sel, input logic [7:0] d, output int e);
    int g;
    g = 0;
    e = -1;
    if (sel) begin d2 = d; v2 = 1'b1; end
    else     begin d1 = d; v1 = 1'b1; end
    while (((sel ? r2 : r1) !== 1'b1) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 3000) begin
      n_err++;
      $display("FAIL push_accept: ready stayed %b for %0d cycles, required 1", sel ? r2 : r1, g);
    end
    @(posedge clk);
    #1 e = cyc;
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (tx1.sig !== 1'b1) begin n_err++; $display("FAIL reset_line: got %b required 1", tx1.sig); end
    n_cmp++; if (r1 !== 1'b1)      begin n_err++; $display("FAIL reset_ready: got %b required 1", r1); end
    n_cmp++; if (b1 !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b required 0", b1); end
    n_cmp++; if (lvl1 !== 3'd0)    begin n_err++; $display("FAIL reset_level: got %0d required 0", lvl1); end
    n_cmp++; if (tx2.sig !== 1'b1) begin n_err++; $display("FAIL reset_line2: got %b required 1", tx2.sig); end
    n_cmp++; if (lvl2 !== 3'd0)    begin n_err++; $display("FAIL reset_level2: got %0d required 0", lvl2); end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int e, s, d, bad;
    logic [9:0] exp_seq;
    exp_seq = 10'b1101001010;
    model_clear(1);
    push(0, 8'hA5, e);
    model_add(e, 8'hA5);
    s = m_start[0];
    n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b required 1", b1); end
    wait_until(e + 1);
    n_cmp++; if (tx1.sig !== 1'b1) begin n_err++; $display("FAIL single_e1_line: got %b required 1", tx1.sig); end
    wait_until(e + 2);
    n_cmp++; if (tx1.sig !== 1'b0) begin n_err++; $display("FAIL single_start_latency: got %b required 0", tx1.sig); end
    wait_until(m_end + 2);
    bad = 0;
    for (int seg = 0; seg < 10; seg++)
      for (int c = 0; c < PW; c++)
        if (log1[s + seg * PW + c] !== exp_seq[seg]) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL single_levels: %0d cycles off, required 0", bad); end
    d = wave_diffs(0, e, m_end + 1);
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL single_wave: %0d diffs, first cycle %0d got %b", d, wd_first, wd_got); end
    n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b required 0", b1); end
  endtask

  task automatic test_back_to_back();
    int e0, e, d;
    model_clear(1);
    push(0, 8'h00, e0); model_add(e0, 8'h00);
    push(0, 8'hFF, e);  model_add(e, 8'hFF);
    push(0, 8'h3C, e);  model_add(e, 8'h3C);
    wait_until(m_end + 2);
    d = wave_diffs(0, e0, m_end + 1);
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL b2b_wave: %0d diffs, first cycle %0d got %b", d, wd_first, wd_got); end
    rx_decode(0, e0, m_end + 1);
    d = rx_diffs();
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL b2b_loopback: %0d bad bytes (got %0d bytes, required 3)", d, rx_q.size()); end
  endtask

  task automatic test_fill();
    int e0, e, e5, d;
    logic [7:0] w;
    model_clear(1);
    w = 8'($urandom); push(0, w, e0); model_add(e0, w);
    wait_until(e0 + 5);
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom); push(0, w, e); model_add(e, w);
    end
    n_cmp++; if (lvl1 !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d required 4", lvl1); end
    n_cmp++; if (r1 !== 1'b0)   begin n_err++; $display("FAIL fill_ready: got %b required 0", r1); end
    w = 8'($urandom);
    push(0, w, e5);
    n_cmp++; if (e5 !== m_start[1]) begin n_err++; $display("FAIL fill_held_accept: edge %0d required %0d", e5, m_start[1]); end
    model_add(e5, w);
    wait_until(m_end + 2);
    d = wave_diffs(0, e0, m_end + 1);
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL fill_wave: %0d diffs, first cycle %0d got %b", d, wd_first, wd_got); end
    rx_decode(0, e0, m_end + 1);
    d = rx_diffs();
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL fill_loopback: %0d bad bytes (got %0d bytes, required 6)", d, rx_q.size()); end
  endtask

  task automatic test_wrap();
    int e0, e, p, d, lbad, ebad;
    logic [7:0] w;
    model_clear(1);
    w = 8'($urandom); push(0, w, e0); model_add(e0, w);
    w = 8'($urandom); push(0, w, e);  model_add(e, w);
    w = 8'($urandom); push(0, w, e);  model_add(e, w);
    n_cmp++; if (lvl1 !== 3'd2) begin n_err++; $display("FAIL wrap_initial_level: got %0d required 2", lvl1); end
    lbad = 0;
    ebad = 0;
    for (int j = 3; j < 15; j++) begin
      p = m_start[j-2] - 1;
      wait_until(p - 1);
      w = 8'($urandom);
      push(0, w, e);
      if (e != p) ebad++;
      model_add(e, w);
      if (lvl1 !== 3'd2) lbad++;
    end
    n_cmp++; if (ebad != 0) begin n_err++; $display("FAIL wrap_push_on_pop: %0d pushes missed the pop edge, required 0", ebad); end
    n_cmp++; if (lbad != 0) begin n_err++; $display("FAIL wrap_level: %0d samples not 2, required 0", lbad); end
    wait_until(m_end + 2);
    d = wave_diffs(0, e0, m_end + 1);
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL wrap_wave: %0d diffs, first cycle %0d got %b", d, wd_first, wd_got); end
    rx_decode(0, e0, m_end + 1);
    d = rx_diffs();
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL wrap_loopback: %0d bad bytes (got %0d bytes, required 15)", d, rx_q.size()); end
  endtask

  task automatic test_stop2();
    int e0, e, d, k, run;
    logic [7:0] w;
    model_clear(2);
    w = 8'($urandom) & 8'h7F; push(1, w, e0); model_add(e0, w);
    w = 8'($urandom);         push(1, w, e);  model_add(e, w);
    wait_until(m_end + 2);
    d = wave_diffs(1, e0, m_end + 1);
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL stop2_wave: %0d diffs, first cycle %0d got %b", d, wd_first, wd_got); end
    // high run between the final data bit (forced 0) and the next start bit
    k = e0 + 2 + 9 * PW;
    while (k < m_end && !(log2[k-1] === 1'b1 && log2[k] === 1'b0)) k++;
    run = 0;
    while (run < 100 && log2[k-1-run] === 1'b1) run++;
    n_cmp++; if (run != 2 * PW) begin n_err++; $display("FAIL stop2_run: high for %0d clocks, required %0d", run, 2 * PW); end
    rx_decode(1, e0, m_end + 1);
    d = rx_diffs();
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL stop2_loopback: %0d bad bytes (got %0d bytes, required 2)", d, rx_q.size()); end
  endtask

  task automatic test_reset_mid();
    int e, e0, d;
    logic [7:0] w;
    model_clear(1);
    w = 8'($urandom) & 8'hEF; push(0, w, e0); model_add(e0, w);
    push(0, 8'($urandom), e);
    push(0, 8'($urandom), e);
    wait_until(m_start[0] + 5 * PW + 3);
    n_cmp++; if (tx1.sig !== 1'b0) begin n_err++; $display("FAIL rstmid_bit4: got %b required 0", tx1.sig); end
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx1.sig !== 1'b1) begin n_err++; $display("FAIL rstmid_line: got %b required 1", tx1.sig); end
    n_cmp++; if (lvl1 !== 3'd0)    begin n_err++; $display("FAIL rstmid_level: got %0d required 0", lvl1); end
    n_cmp++; if (r1 !== 1'b1)      begin n_err++; $display("FAIL rstmid_ready: got %b required 1", r1); end
    n_cmp++; if (b1 !== 1'b0)      begin n_err++; $display("FAIL rstmid_busy: got %b required 0", b1); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    model_clear(1);
    w = 8'($urandom);
    push(0, w, e0); model_add(e0, w);
    wait_until(m_end + 2);
    d = wave_diffs(0, e0, m_end + 1);
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL rstmid_fresh_wave: %0d diffs, first cycle %0d got %b", d, wd_first, wd_got); end
    rx_decode(0, e0, m_end + 1);
    d = rx_diffs();
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL rstmid_loopback: %0d bad bytes (got %0d bytes, required 1)", d, rx_q.size()); end
  endtask

  task automatic test_random();
    int e0, e, d;
    logic [7:0] w;
    model_clear(1);
    e0 = -1;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 130)) @(negedge clk);
      w = 8'($urandom);
      push(0, w, e);
      if (e0 < 0) e0 = e;
      model_add(e, w);
    end
    wait_until(m_end + 2);
    d = wave_diffs(0, e0, m_end + 1);
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL random_wave: %0d diffs, first cycle %0d got %b", d, wd_first, wd_got); end
    rx_decode(0, e0, m_end + 1);
    d = rx_diffs();
    n_cmp++; if (d != 0) begin n_err++; $display("FAIL random_loopback: %0d bad bytes (got %0d bytes, required 10)", d, rx_q.size()); end
    n_cmp++; if (b1 !== 1'b0) begin n_err++; $display("FAIL random_idle_busy: got %b required 0", b1); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_wrap();
    test_stop2();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
